// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
// Optional feature macro used by this stage: FETCH_MISALIGN_TRAP_EN.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small synchronous FIFO of fetched {pc, instr} entries.
// Flush has priority over push and pop.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  fetch_entry_t  entry_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= entry_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, single-outstanding imem fetch, buffered decode hand-off.
// FETCH_MISALIGN_TRAP_EN: trap and halt on misaligned redirect targets.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_new,
  input  logic        pc_new_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic        misalign_trap
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_REQ  = ST_REQ;
  localparam logic [1:0] S_WAIT = ST_WAIT;

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          drop_q, drop_d;
  logic          trap_q, trap_d;
  fetch_entry_t  last_q;

  logic [31:0]   tgt;
  logic          mis;
  logic          in_idle, in_req, in_wait;
  logic          granted, resp;
  logic          push, pop;
  logic          can_issue;
  logic [CW-1:0] cnt_d;

  fetch_entry_t  head;
  fetch_entry_t  resp_e;
  logic          buf_full, buf_empty;
  logic [CW-1:0] buf_cnt;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt = pc_new;
  assign mis = |pc_new[1:0];
`else
  assign tgt = pc_new & ~32'h3;
  assign mis = 1'b0;
`endif

  assign in_idle = (state_q == S_IDLE);
  assign in_req  = (state_q == S_REQ);
  assign in_wait = (state_q == S_WAIT);
  assign granted = in_req & imem_gnt;
  assign resp    = in_wait & imem_rvalid;

  assign push = resp & ~drop_q & ~pc_new_en & ~buf_full;
  assign pop  = ~buf_empty & if_ready;

  // Occupancy after this edge decides whether another request may go out.
  assign cnt_d = pc_new_en ? '0 : buf_cnt + CW'(push) - CW'(pop);

  assign trap_d    = pc_new_en ? mis : trap_q;
  assign can_issue = ~trap_d & (cnt_d < DEPTH_C);

  assign pc_d = pc_new_en          ? tgt :
                (granted & ~drop_q) ? addr_q + PC_STEP :
                                      pc_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drop_d  = drop_q;
    if (pc_new_en && !in_idle) drop_d = 1'b1;
    unique case (1'b1)
      in_req: begin
        if (imem_gnt) state_d = S_WAIT;
      end
      resp | in_idle: begin
        drop_d = 1'b0;
        if (can_issue) begin
          state_d = S_REQ;
          addr_d  = pc_d;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      drop_q  <= 1'b0;
      trap_q  <= 1'b0;
      last_q  <= '{pc: 32'h0, instr: NOP_INSTR};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
      trap_q  <= trap_d;
      if (!buf_empty) last_q <= head;
    end
  end

  assign resp_e = '{pc: addr_q, instr: imem_rdata};

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .entry_i (resp_e),
    .pop_i   (pop),
    .flush_i (pc_new_en),
    .head_o  (head),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_cnt)
  );

  assign imem_req      = in_req;
  assign imem_addr     = addr_q;
  assign if_valid      = ~buf_empty;
  assign if_pc         = buf_empty ? last_q.pc : head.pc;
  assign if_instr      = buf_empty ? last_q.instr : head.instr;
  assign misalign_trap = trap_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a
// transaction-level model of the fetch rules.
module tb_fetch_unit;

  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] KEY   = 32'hDEAD_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_new = '0;
  logic        pc_new_en = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready = 1'b0;
  logic        misalign_trap;

  fetch_unit #(
    .RESET_PC  (RPC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_new        (pc_new),
    .pc_new_en     (pc_new_en),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_ready      (if_ready),
    .misalign_trap (misalign_trap)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // reference model state
  ent_t        mq[$];
  ent_t        m_last;
  bit          m_known = 0;
  bit          m_rst = 0;
  bit          m_busy = 0;
  bit          m_gr = 0;
  bit          m_drop = 0;
  bit          m_trap = 0;
  logic [31:0] m_pc = RPC;
  logic [31:0] m_addr = RPC;
  ent_t        me;
  bit          m_redir, m_pop, m_push, m_mis;
  logic [31:0] m_tgt;

  // observation logs and memory responder state
  logic [31:0] gaddr[$];
  ent_t        dec[$];
  int          mode = 0;
  bit          mb = 0;
  int          mw = 0;
  logic [31:0] maddr = '0;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin : model
    if (m_known) begin
      cmp("imem_req", 32'(imem_req), 32'(m_busy && !m_gr));
      if (m_busy && !m_gr) cmp("imem_addr", imem_addr, m_addr);
      if (m_rst) cmp("imem_addr_rst", imem_addr, RPC);
      cmp("if_valid", 32'(if_valid), 32'(mq.size() != 0));
      cmp("if_pc", if_pc, (mq.size() != 0) ? mq[0].pc : m_last.pc);
      cmp("if_instr", if_instr,
          (mq.size() != 0) ? mq[0].instr : m_last.instr);
      cmp("misalign_trap", 32'(misalign_trap), 32'(m_trap));
    end
    if (rst_n && m_known) begin
      if (imem_req && imem_gnt) gaddr.push_back(imem_addr);
      if (if_valid && if_ready && !pc_new_en)
        dec.push_back('{if_pc, if_instr});
    end
    if (!rst_n) begin
      mq.delete();
      m_last  = '{32'h0, NOP};
      m_busy  = 0;
      m_gr    = 0;
      m_drop  = 0;
      m_trap  = 0;
      m_pc    = RPC;
      m_addr  = RPC;
      m_known = 1;
      m_rst   = 1;
    end else if (m_known) begin
      m_redir = pc_new_en;
`ifdef FETCH_MISALIGN_TRAP_EN
      m_tgt = pc_new;
      m_mis = (pc_new[1:0] != 2'b00);
`else
      m_tgt = pc_new & ~32'h3;
      m_mis = 0;
`endif
      if (mq.size() != 0) m_last = mq[0];
      m_pop  = (mq.size() != 0) && if_ready && !m_redir;
      m_push = 0;
      if (m_busy && !m_gr) begin
        if (imem_gnt) begin
          m_gr = 1;
          if (!m_drop && !m_redir) m_pc = m_pc + 32'd4;
        end
      end else if (m_busy && imem_rvalid) begin
        m_busy = 0;
        if (!m_drop && !m_redir) begin
          m_push   = 1;
          me.pc    = m_addr;
          me.instr = imem_rdata;
        end
      end
      if (m_redir) begin
        mq.delete();
        m_pc   = m_tgt;
        m_trap = m_mis;
        if (m_busy) m_drop = 1;
      end else begin
        if (m_pop) mq.delete(0);
        if (m_push) mq.push_back(me);
      end
      if (!m_busy && !m_trap && mq.size() < DEPTH) begin
        m_busy = 1;
        m_gr   = 0;
        m_addr = m_pc;
        m_drop = 0;
      end
      m_rst = 0;
    end
  end

  task automatic mem_drive();
    if (!rst_n) begin
      mb          = 0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      return;
    end
    if (imem_rvalid) mb = 0;
    if (imem_gnt) begin
      mb = 1;
      mw = (mode == 0) ? 0 : (mode == 1) ? 2 : int'($urandom_range(0, 3));
    end
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mb) begin
      if (mw == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = (mode == 2) ? $urandom : (maddr ^ KEY);
      end else begin
        mw--;
      end
    end
    imem_gnt = 1'b0;
    if (imem_req && !mb) begin
      imem_gnt = (mode != 2) || ($urandom_range(0, 3) != 0);
      if (imem_gnt) maddr = imem_addr;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    pc_new_en = 1'b0;
    mem_drive();
  endtask

  task automatic clear_logs();
    gaddr.delete();
    dec.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic redirect_idle(input logic [31:0] a);
    mode     = 0;
    if_ready = 1'b0;
    do_reset();
    repeat (16) step();
    pc_new    = a;
    pc_new_en = 1'b1;
    step();
    clear_logs();
    if_ready = 1'b1;
  endtask

  initial begin
    // reset values and in-order stream with immediate grant, rvalid +1
    mode     = 0;
    if_ready = 1'b1;
    rst_n    = 1'b0;
    repeat (3) step();
    cmp("rst_req", 32'(imem_req), 32'h0);
    cmp("rst_addr", imem_addr, RPC);
    cmp("rst_valid", 32'(if_valid), 32'h0);
    cmp("rst_pc", if_pc, 32'h0);
    cmp("rst_instr", if_instr, NOP);
    cmp("rst_trap", 32'(misalign_trap), 32'h0);
    rst_n = 1'b1;
    clear_logs();
    step();
    cmp("first_req", 32'(imem_req), 32'h1);
    repeat (12) step();
    cmp("seq_ngrant", 32'(gaddr.size() >= 3), 32'h1);
    cmp("seq_addr0", gaddr[0], 32'h0);
    cmp("seq_addr1", gaddr[1], 32'h4);
    cmp("seq_addr2", gaddr[2], 32'h8);
    cmp("seq_ndec", 32'(dec.size() >= 3), 32'h1);
    cmp("seq_pc0", dec[0].pc, 32'h0);
    cmp("seq_pc1", dec[1].pc, 32'h4);
    cmp("seq_pc2", dec[2].pc, 32'h8);
    cmp("seq_in0", dec[0].instr, 32'hDEAD_0000);
    cmp("seq_in2", dec[2].instr, 32'hDEAD_0008);

    // backpressure: two entries then no requests; one pop -> one request
    if_ready = 1'b0;
    do_reset();
    clear_logs();
    repeat (16) step();
    cmp("full_ngrant", 32'(gaddr.size()), 32'd2);
    cmp("full_req", 32'(imem_req), 32'h0);
    cmp("full_valid", 32'(if_valid), 32'h1);
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    repeat (12) step();
    cmp("pop1_ngrant", 32'(gaddr.size()), 32'd3);
    cmp("pop1_req", 32'(imem_req), 32'h0);

    // redirect while a response is outstanding
    mode     = 1;
    if_ready = 1'b0;
    do_reset();
    clear_logs();
    for (int i = 0; i < 40 && gaddr.size() < 2; i++) step();
    cmp("wait_reached", 32'(gaddr.size()), 32'd2);
    cmp("wait_valid", 32'(if_valid), 32'h1);
    pc_new    = 32'h100;
    pc_new_en = 1'b1;
    step();
    cmp("redir_valid", 32'(if_valid), 32'h0);
    if_ready = 1'b1;
    for (int i = 0; i < 40 && dec.size() < 1; i++) step();
    cmp("redir_addr", gaddr[2], 32'h100);
    cmp("redir_pc", dec[0].pc, 32'h100);
    cmp("redir_in", dec[0].instr, 32'hDEAD_0100);

    // redirect coinciding with rvalid and a decode pop
    mode     = 0;
    if_ready = 1'b0;
    do_reset();
    clear_logs();
    for (int i = 0; i < 30 && !(imem_rvalid && if_valid); i++) step();
    cmp("coinc_reached", 32'(imem_rvalid && if_valid), 32'h1);
    if_ready  = 1'b1;
    pc_new    = 32'h300;
    pc_new_en = 1'b1;
    step();
    cmp("coinc_valid", 32'(if_valid), 32'h0);
    clear_logs();
    repeat (10) step();
    cmp("coinc_addr", gaddr[0], 32'h300);
    cmp("coinc_pc", dec[0].pc, 32'h300);

    // address wrap at the top of the space
    redirect_idle(32'hFFFF_FFF8);
    repeat (12) step();
    cmp("wrap_a0", gaddr[0], 32'hFFFF_FFF8);
    cmp("wrap_a1", gaddr[1], 32'hFFFF_FFFC);
    cmp("wrap_a2", gaddr[2], 32'h0000_0000);
    cmp("wrap_pc2", dec[2].pc, 32'h0000_0000);

    // misaligned redirect target
    redirect_idle(32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    cmp("mis_trap", 32'(misalign_trap), 32'h1);
    cmp("mis_req", 32'(imem_req), 32'h0);
    repeat (10) step();
    cmp("mis_halt", 32'(gaddr.size()), 32'd0);
    pc_new    = 32'h200;
    pc_new_en = 1'b1;
    step();
    cmp("mis_clear", 32'(misalign_trap), 32'h0);
    repeat (10) step();
    cmp("mis_resume", gaddr[0], 32'h200);
    cmp("mis_pc", dec[0].pc, 32'h200);
`else
    repeat (10) step();
    cmp("mis_trap", 32'(misalign_trap), 32'h0);
    cmp("mis_addr", gaddr[0], 32'h100);
    cmp("mis_pc", dec[0].pc, 32'h100);
`endif

    // reset mid-transaction, stale rvalid afterwards is ignored
    mode     = 1;
    if_ready = 1'b1;
    do_reset();
    clear_logs();
    for (int i = 0; i < 20 && gaddr.size() < 1; i++) step();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n       = 1'b1;
    mode        = 0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    clear_logs();
    step();
    cmp("stale_req", 32'(imem_req), 32'h1);
    repeat (12) step();
    cmp("stale_addr", gaddr[0], 32'h0);
    cmp("stale_pc", dec[0].pc, 32'h0);
    cmp("stale_in", dec[0].instr, 32'hDEAD_0000);

    // randomized traffic
    mode = 2;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step();
      if_ready = ($urandom_range(0, 3) != 0);
      rst_n    = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 19) == 0) begin
        pc_new = ($urandom_range(0, 5) == 0) ? $urandom
                                             : ($urandom & ~32'h3);
        pc_new_en = 1'b1;
      end
    end
    rst_n = 1'b1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
